// File: rtl/wave_key_ctrl_if.sv
// Bundle between the key front end and its consumers: raw active-low buttons
// in, waveform parameter registers and the update strobe out.
interface wave_key_ctrl_if;
  logic        key_wave;
  logic        key_amp;
  logic        key_up;
  logic        key_down;
  logic [1:0]  wave_sel;
  logic [19:0] wave_freq;
  logic [1:0]  wave_a;
  logic        param_upd;

  // master: the controller that owns the parameter registers
  modport master (
    input  key_wave, key_amp, key_up, key_down,
    output wave_sel, wave_freq, wave_a, param_upd
  );

  // slave: the button source / parameter consumer side
  modport slave (
    output key_wave, key_amp, key_up, key_down,
    input  wave_sel, wave_freq, wave_a, param_upd
  );
endinterface

// File: rtl/wave_key_ctrl.sv
// Key front end of the DDS board: two-flop synchronizers, per-key debounce,
// up/down hold-and-repeat FSMs and the waveform parameter registers.
// Key index order everywhere: 0 wave, 1 amp, 2 up, 3 down.
module wave_key_ctrl #(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned FREQ_MIN      = 500,
  parameter int unsigned FREQ_MAX      = 50_000,
  parameter int unsigned FREQ_STEP     = 500
) (
  input  logic            clk,
  input  logic            rst,
  wave_key_ctrl_if.master bus
);

  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  localparam logic [20:0] F_STEP21  = 21'(FREQ_STEP);
  localparam logic [20:0] F_MAX21   = 21'(FREQ_MAX);
  localparam logic [20:0] F_FLOOR21 = 21'(FREQ_MIN + FREQ_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Saturating increment, evaluated one bit wider so the sum cannot wrap.
  function automatic logic [19:0] freq_inc(input logic [19:0] f);
    logic [20:0] sum;
    sum = {1'b0, f} + F_STEP21;
    if (sum > F_MAX21) return 20'(FREQ_MAX);
    return sum[19:0];
  endfunction

  // Saturating decrement: anything below MIN+STEP lands on MIN.
  function automatic logic [19:0] freq_dec(input logic [19:0] f);
    logic [20:0] diff;
    diff = {1'b0, f} - F_STEP21;
    if ({1'b0, f} < F_FLOOR21) return 20'(FREQ_MIN);
    return diff[19:0];
  endfunction

  logic [3:0]       key_raw;
  logic [3:0]       sync_p0_q, sync_p1_q;
  logic [3:0]       filt_q, filt_d;
  logic [3:0]       filt_dly_q;
  logic [3:0]       press_q, press_d;
  logic [DB_W-1:0]  db_cnt_q [4];
  logic [DB_W-1:0]  db_cnt_d [4];

  rpt_state_e       rpt_state_q [2];
  logic [RPT_W-1:0] rpt_cnt_q   [2];
  logic [1:0]       step;

  logic [1:0]  wave_sel_q, wave_sel_d;
  logic [19:0] wave_freq_q, wave_freq_d;
  logic [1:0]  wave_a_q, wave_a_d;
  logic        param_upd_q, param_upd_d;

  assign key_raw = {bus.key_down, bus.key_up, bus.key_amp, bus.key_wave};

  // Debounce: count consecutive cycles of disagreement, accept on the last one.
  always_comb begin
    filt_d  = filt_q;
    press_d = filt_dly_q & ~filt_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync_p1_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          filt_d[i] = sync_p1_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Synchronizer stages, filtered levels and registered press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0_q  <= '1;
      sync_p1_q  <= '1;
      filt_q     <= '1;
      filt_dly_q <= '1;
      press_q    <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync_p0_q  <= key_raw;
      sync_p1_q  <= sync_p0_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      press_q    <= press_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Frequency step requests: on the press itself, at hold expiry, then each repeat period.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      step[j] = 1'b0;
      if (!filt_q[j+2]) begin
        case (rpt_state_q[j])
          IDLE:    step[j] = press_q[j+2];
          HOLD:    step[j] = (rpt_cnt_q[j] == HOLD_LAST);
          REPEAT:  step[j] = (rpt_cnt_q[j] == REP_LAST);
          default: step[j] = 1'b0;
        endcase
      end
    end
  end

  // Hold/repeat FSMs for up (0) and down (1); release always returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        rpt_state_q[j] <= IDLE;
        rpt_cnt_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (filt_q[j+2]) begin
          rpt_state_q[j] <= IDLE;
          rpt_cnt_q[j]   <= '0;
        end else begin
          case (rpt_state_q[j])
            IDLE: begin
              if (press_q[j+2]) begin
                rpt_state_q[j] <= HOLD;
                rpt_cnt_q[j]   <= '0;
              end
            end
            HOLD: begin
              if (rpt_cnt_q[j] == HOLD_LAST) begin
                rpt_state_q[j] <= REPEAT;
                rpt_cnt_q[j]   <= '0;
              end else begin
                rpt_cnt_q[j] <= rpt_cnt_q[j] + RPT_W'(1);
              end
            end
            REPEAT: begin
              if (rpt_cnt_q[j] == REP_LAST) begin
                rpt_cnt_q[j] <= '0;
              end else begin
                rpt_cnt_q[j] <= rpt_cnt_q[j] + RPT_W'(1);
              end
            end
            default: begin
              rpt_state_q[j] <= IDLE;
              rpt_cnt_q[j]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Next parameter values; opposing up/down steps cancel, strobe only on real change.
  always_comb begin
    wave_sel_d  = wave_sel_q;
    wave_a_d    = wave_a_q;
    wave_freq_d = wave_freq_q;
    if (press_q[0]) wave_sel_d = wave_sel_q + 2'd1;
    if (press_q[1]) wave_a_d   = wave_a_q + 2'd1;
    if (step[0] && !step[1]) begin
      wave_freq_d = freq_inc(wave_freq_q);
    end else if (step[1] && !step[0]) begin
      wave_freq_d = freq_dec(wave_freq_q);
    end
    param_upd_d = (wave_sel_d != wave_sel_q) || (wave_a_d != wave_a_q) ||
                  (wave_freq_d != wave_freq_q);
  end

  // Parameter registers and update strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave_sel_q  <= 2'd0;
      wave_freq_q <= 20'(FREQ_MIN);
      wave_a_q    <= 2'd0;
      param_upd_q <= 1'b0;
    end else begin
      wave_sel_q  <= wave_sel_d;
      wave_freq_q <= wave_freq_d;
      wave_a_q    <= wave_a_d;
      param_upd_q <= param_upd_d;
    end
  end

  assign bus.wave_sel  = wave_sel_q;
  assign bus.wave_freq = wave_freq_q;
  assign bus.wave_a    = wave_a_q;
  assign bus.param_upd = param_upd_q;

endmodule

// File: tb/tb_wave_key_ctrl.sv
// Bench for wave_key_ctrl: a table of key-press records, hand-timed corner
// sequences and a randomized run, all checked against a timing-level model.
module tb_wave_key_ctrl;

  localparam int DB    = 4;
  localparam int HOLD  = 20;
  localparam int REP   = 8;
  localparam int FMIN  = 500;
  localparam int FMAX  = 50_000;
  localparam int FSTEP = 500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_key_ctrl_if bus ();

  wave_key_ctrl #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model (event times, not registers) ----------------
  // A key level is accepted once the twice-delayed raw sample has disagreed with
  // the accepted level on DB consecutive edges; a press shows on the outputs two
  // edges after acceptance. Up/down steps fall at P, P+HOLD, P+HOLD+k*REP for all
  // such edges not later than the edge the release is accepted.
  logic [3:0] m_hist [4];
  int m_n = 0;
  int m_lvl [4];
  int m_run [4];
  int m_press_at [4];
  int m_p [2];
  int m_rel [2];
  bit m_act [2];
  int m_sel, m_freq, m_a;
  bit m_upd;

  function automatic bit due(input int j);
    int d;
    d = m_n - m_p[j];
    if (!m_act[j] || d < 0 || m_n > m_rel[j]) return 1'b0;
    return (d == 0) || (d >= HOLD && ((d - HOLD) % REP) == 0);
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] raw;
    int s, nsel, nfreq, na;
    bit wv, am, up, dn;
    raw = {bus.key_down, bus.key_up, bus.key_amp, bus.key_wave};
    if (rst) begin
      m_sel = 0; m_freq = FMIN; m_a = 0; m_upd = 1'b0;
      m_hist[m_n % 4]       = 4'hF;
      m_hist[(m_n + 3) % 4] = 4'hF;
      for (int k = 0; k < 4; k++) begin
        m_lvl[k] = 1; m_run[k] = 0; m_press_at[k] = -1;
      end
      for (int j = 0; j < 2; j++) begin
        m_act[j] = 1'b0; m_p[j] = 0; m_rel[j] = 0;
      end
    end else begin
      m_hist[m_n % 4] = raw;
      for (int k = 0; k < 4; k++) begin
        s = (m_n >= 2) ? int'(m_hist[(m_n + 2) % 4][k]) : 1;
        if (s != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_lvl[k] = s;
            m_run[k] = 0;
            if (s == 0) m_press_at[k] = m_n + 2;
            else if (k >= 2) m_rel[k-2] = m_n;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (m_press_at[j+2] == m_n) begin
          m_act[j] = 1'b1; m_p[j] = m_n; m_rel[j] = 32'h7fff_ffff;
        end
      end
      wv = (m_press_at[0] == m_n);
      am = (m_press_at[1] == m_n);
      up = due(0);
      dn = due(1);
      nsel  = wv ? (m_sel + 1) % 4 : m_sel;
      na    = am ? (m_a + 1) % 4 : m_a;
      nfreq = m_freq;
      if (up && !dn) nfreq = (m_freq + FSTEP > FMAX) ? FMAX : m_freq + FSTEP;
      if (dn && !up) nfreq = (m_freq < FMIN + FSTEP) ? FMIN : m_freq - FSTEP;
      m_upd  = (nsel != m_sel) || (na != m_a) || (nfreq != m_freq);
      m_sel  = nsel;
      m_a    = na;
      m_freq = nfreq;
    end
    m_n++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and comparing to the model.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.param_upd === 1'b1) upd_seen++;
      if (chk_en) begin
        check("model_sel",  int'(bus.wave_sel),  m_sel);
        check("model_freq", int'(bus.wave_freq), m_freq);
        check("model_amp",  int'(bus.wave_a),    m_a);
        check("model_upd",  int'(bus.param_upd), int'(m_upd));
      end
    end
  endtask

  // Mask bit set = button pressed; order {down, up, amp, wave}.
  task automatic set_keys(input logic [3:0] m);
    bus.key_wave = ~m[0];
    bus.key_amp  = ~m[1];
    bus.key_up   = ~m[2];
    bus.key_down = ~m[3];
  endtask

  task automatic do_reset();
    set_keys(4'b0000);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  typedef struct {
    logic [3:0] keys;
    int         hold;
    int         sel;
    int         freq;
    int         amp;
    int         pulses;
  } vec_t;

  vec_t vecs [15];
  int base;

  initial begin
    // Each record starts from the state the previous one left.
    vecs[0]  = '{4'b0100, 10, 0, 1000, 0, 1};  // up
    vecs[1]  = '{4'b0001, 10, 1, 1000, 0, 1};  // wave 0->1
    vecs[2]  = '{4'b0001, 10, 2, 1000, 0, 1};
    vecs[3]  = '{4'b0001, 10, 3, 1000, 0, 1};
    vecs[4]  = '{4'b0001, 10, 0, 1000, 0, 1};  // wave wraps
    vecs[5]  = '{4'b0010, 10, 0, 1000, 1, 1};  // amp
    vecs[6]  = '{4'b0010, 10, 0, 1000, 2, 1};
    vecs[7]  = '{4'b0010, 10, 0, 1000, 3, 1};
    vecs[8]  = '{4'b0001, 10, 1, 1000, 3, 1};
    vecs[9]  = '{4'b0011, 10, 2, 1000, 0, 1};  // wave+amp together, amp wraps
    vecs[10] = '{4'b1100, 10, 2, 1000, 0, 0};  // up+down cancel
    vecs[11] = '{4'b1000, 10, 2,  500, 0, 1};  // down
    vecs[12] = '{4'b1000, 10, 2,  500, 0, 0};  // floor
    vecs[13] = '{4'b0111, 10, 3, 1000, 1, 1};  // wave+amp+up together
    vecs[14] = '{4'b0000, 10, 3, 1000, 1, 0};  // idle

    // Reset: held for three edges with keys released.
    set_keys(4'b0000);
    rst = 1'b1;
    tick(3);
    check("rst_sel",  int'(bus.wave_sel),  0);
    check("rst_freq", int'(bus.wave_freq), FMIN);
    check("rst_amp",  int'(bus.wave_a),    0);
    check("rst_upd",  int'(bus.param_upd), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(2);

    // Clean press of up: update lands on edge DB+3 with a single strobe.
    set_keys(4'b0100);
    tick(7);
    check("press_before", int'(bus.wave_freq), 500);
    tick(1);
    check("press_freq", int'(bus.wave_freq), 1000);
    check("press_upd",  int'(bus.param_upd), 1);
    tick(1);
    check("press_upd_end", int'(bus.param_upd), 0);
    tick(1);
    set_keys(4'b0000);
    base = upd_seen;
    tick(15);
    check("release_freq", int'(bus.wave_freq), 1000);
    check("release_pulses", upd_seen - base, 0);

    // Bounce on wave, then a stable low.
    do_reset();
    base = upd_seen;
    for (int i = 0; i < 6; i++) begin
      set_keys((i % 2 == 0) ? 4'b0001 : 4'b0000);
      tick(2);
    end
    set_keys(4'b0001);
    tick(7);
    check("bounce_before", int'(bus.wave_sel), 0);
    tick(1);
    check("bounce_sel", int'(bus.wave_sel), 1);
    tick(10);
    set_keys(4'b0000);
    tick(15);
    check("bounce_final", int'(bus.wave_sel), 1);
    check("bounce_pulses", upd_seen - base, 1);

    // Table of single and combined presses.
    do_reset();
    for (int v = 0; v < 15; v++) begin
      base = upd_seen;
      set_keys(vecs[v].keys);
      tick(vecs[v].hold);
      set_keys(4'b0000);
      tick(15);
      check($sformatf("vec%0d_sel", v),    int'(bus.wave_sel),  vecs[v].sel);
      check($sformatf("vec%0d_freq", v),   int'(bus.wave_freq), vecs[v].freq);
      check($sformatf("vec%0d_amp", v),    int'(bus.wave_a),    vecs[v].amp);
      check($sformatf("vec%0d_pulses", v), upd_seen - base,     vecs[v].pulses);
    end

    // Auto-repeat: steps at edges 7, 27, 35, 43, 51, 59 for a 60-cycle hold.
    do_reset();
    base = upd_seen;
    set_keys(4'b0100);
    tick(27);
    check("hold_before", int'(bus.wave_freq), 1000);
    tick(1);
    check("hold_expiry", int'(bus.wave_freq), 1500);
    tick(32);
    set_keys(4'b0000);
    tick(20);
    check("repeat_freq",   int'(bus.wave_freq), 3500);
    check("repeat_pulses", upd_seen - base, 6);

    // Long hold saturates at FREQ_MAX with exactly one strobe per real change.
    do_reset();
    base = upd_seen;
    set_keys(4'b0100);
    tick(1000);
    set_keys(4'b0000);
    tick(15);
    check("sat_freq",   int'(bus.wave_freq), FMAX);
    check("sat_pulses", upd_seen - base, (FMAX - FMIN) / FSTEP);

    // Reset while repeating; key held through reset is a fresh press.
    do_reset();
    set_keys(4'b0100);
    tick(40);
    rst = 1'b1;
    tick(1);
    check("midrst_sel",  int'(bus.wave_sel),  0);
    check("midrst_freq", int'(bus.wave_freq), FMIN);
    check("midrst_amp",  int'(bus.wave_a),    0);
    check("midrst_upd",  int'(bus.param_upd), 0);
    rst = 1'b0;
    tick(7);
    check("midrst_before", int'(bus.wave_freq), 500);
    tick(1);
    check("midrst_repress", int'(bus.wave_freq), 1000);
    set_keys(4'b0000);
    tick(15);

    // Randomized key activity with occasional resets.
    do_reset();
    for (int it = 0; it < 250; it++) begin
      set_keys(4'($urandom_range(0, 15)));
      tick($urandom_range(1, 40));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    set_keys(4'b0000);
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_key_ctrl.md
Name: wave_key_ctrl

Overview:
- User-input front end of the DDS board.
- Debounces four raw push-buttons and maintains the waveform parameter registers: waveform select, output frequency and amplitude index.
- Its outputs drive both the DDS core and the 7-segment display stage directly.
- Holding up/down auto-repeats the frequency step.

Parameters:
- DB_CYCLES, 1_000_000, stable cycles required to accept a key level change (20 ms at 50 MHz).
- HOLD_CYCLES, 25_000_000, cycles up/down must stay pressed before auto-repeat starts.
- REPEAT_CYCLES, 5_000_000, auto-repeat period once repeating.
- FREQ_MIN, 500, lower frequency bound and reset value (Hz).
- FREQ_MAX, 50_000, upper frequency bound (Hz).
- FREQ_STEP, 500, frequency increment/decrement (Hz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- key_wave  in  1  raw button, active-low, asynchronous; cycles waveform.
- key_amp  in  1  raw button, active-low, asynchronous; cycles amplitude.
- key_up  in  1  raw button, active-low, asynchronous; frequency +FREQ_STEP.
- key_down  in  1  raw button, active-low, asynchronous; frequency -FREQ_STEP.
- wave_sel  out  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
- wave_freq  out  20  output frequency in Hz, unsigned.
- wave_a  out  2  amplitude index, 0 = full scale … 3 = smallest.
- param_upd  out  1  one-cycle pulse on the cycle after any output value changes.

Behaviour:
- Interface: single clock clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk. All state is clk-domain registers.
- Reset values: wave_sel=0, wave_freq=FREQ_MIN, wave_a=0, param_upd=0. All counters=0, FSMs=IDLE. Synchronizer and filtered key states=1 (released).
- Reset mid-operation aborts any debounce or repeat in progress. A key held through reset release is treated as a new press after DB_CYCLES.
- Synchronizer: each key passes through 2 flip-flops.
- Debounce, per key:
  - Counter increments while the synchronized level differs from the filtered level.
  - Counter clears to 0 on any cycle the two levels match (a bounce restarts the count).
  - When the counter reaches DB_CYCLES-1 while still differing, the filtered level takes the new value and the counter clears.
  - A press event is a one-cycle pulse on the filtered 1->0 transition. Releases generate no event.
- Latency: a raw level applied before edge 0 and held stable produces a press pulse at edge DB_CYCLES+2. The affected output register updates at edge DB_CYCLES+3. param_upd is high for the cycle following that update.
- key_wave press: wave_sel <= wave_sel+1 mod 4 (3 wraps to 0).
- key_amp press: wave_a <= wave_a+1 mod 4 (3 wraps to 0).
- Up/down repeat FSM, one per key; states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on press event; the step is applied immediately and the hold counter clears.
  - HOLD: counter counts while filtered level=0. On reaching HOLD_CYCLES-1 -> REPEAT, one step applied, counter clears.
  - REPEAT: one step every REPEAT_CYCLES cycles while pressed.
  - Any state -> IDLE the cycle the filtered level returns to 1.
- Frequency arithmetic:
  - Computed in 21-bit width.
  - Up: if wave_freq+FREQ_STEP > FREQ_MAX then FREQ_MAX, else the sum.
  - Down: if wave_freq < FREQ_MIN+FREQ_STEP then FREQ_MIN, else the difference.
  - Saturation, no wrap.
- Simultaneous up and down steps in the same cycle: wave_freq unchanged and no param_upd. Each FSM still advances normally.
- Simultaneous wave, amp and frequency steps in the same cycle: all apply in that cycle; a single param_upd pulse.
- param_upd is asserted only if at least one of wave_sel, wave_freq, wave_a actually changed. A step while saturated at FREQ_MIN/FREQ_MAX produces no pulse.
- Counter widths are $clog2 of the corresponding parameter. Parameters must satisfy FREQ_MIN+FREQ_STEP <= FREQ_MAX < 2^20.

Test Plan:
Use DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, defaults otherwise.
- Reset check: rst high 3 cycles with all keys high -> wave_sel=0, wave_freq=500, wave_a=0, param_upd=0. Assert rst mid-repeat -> same values on the next edge, FSMs IDLE.
- Clean press: key_up low for 10 cycles -> wave_freq 500->1000 exactly 7 edges after the key falls, one param_upd pulse, no further step (under HOLD). Release -> no change.
- Bounce: key_wave toggles low/high every 2 cycles for 12 cycles, then stays low -> exactly one wave_sel increment, 7 edges after the final stable low. Four clean presses from wave_sel=0 -> 1,2,3,0.
- Auto-repeat: key_up held 60 cycles from 500 -> 1000 at press, 1500 at HOLD expiry, then +500 every 8 cycles until release. Hold from 49_000 -> saturates at 50_000, no param_upd while saturated.
- Floor and conflict: key_down at 500 -> stays 500, no param_upd. Press key_up and key_down with identical timing at 1000 -> stays 1000, no param_upd.
- Combined: key_amp and key_wave pressed identically at wave_a=3, wave_sel=1 -> wave_a=0, wave_sel=2 in the same cycle, single param_upd pulse.
